ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte from the core to the attached keyboard, for example 0xED to set the LEDs or 0xFF to reset. It implements the host side of the PS/2 request-to-send sequence and drives the clock and data lines open-drain. It shares both lines with the existing PS/2 receive path and runs on the 7 MHz video clock. While a transmission is in progress the receiver must ignore line activity (gate it on `busy`).

---
 rtl/ps2_pkg.sv | 38 +++
 rtl/ps2_line_sync.sv | 41 ++++
 rtl/ps2_tx.sv | 218 +++++++++++++++++++++
 tb/tb_ps2_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmit/receive paths.
package ps2_pkg;

    // Host transmit FSM states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        REQ      = 3'd2,
        DATA     = 3'd3,
        ACK      = 3'd4,
        WAITIDLE = 3'd5
    } ps2_tx_state_t;

    // Latched command byte together with its parity bit
    typedef struct packed {
        logic       parity;
        logic [7:0] data;
    } tx_frame_t;

    localparam int unsigned BIT_CNT_W          = 4;
    localparam int unsigned LAST_DATA_FALL     = 9;
    localparam int unsigned STOP_FALL          = 10;
    localparam int unsigned ACK_FALL           = 11;

    localparam int unsigned DEF_INHIBIT_CYCLES = 840;     // 120 us at 7 MHz
    localparam int unsigned DEF_TIMEOUT_CYCLES = 105000;  // 15 ms at 7 MHz

    // 3-sample majority vote
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    // Odd parity bit: makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: PS/2 line conditioning -- 2-flop synchronizers, 3-sample
// majority filter on the clock line and a filtered falling-edge pulse.
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic ck,
    input  logic dt,
    output logic ck_filt,
    output logic dt_sync,
    output logic fall
);

    logic [1:0] ck_meta;
    logic [2:0] ck_hist;
    logic       dt_meta;
    logic       ck_vote;

    assign ck_vote = maj3(ck_hist);

    // Synchronize both lines, filter the clock and flag filtered 1->0 transitions
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_meta <= 2'b11;
            ck_hist <= 3'b111;
            ck_filt <= 1'b1;
            fall    <= 1'b0;
            dt_meta <= 1'b1;
            dt_sync <= 1'b1;
        end else begin
            ck_meta <= {ck_meta[0], ck};
            ck_hist <= {ck_hist[1:0], ck_meta[1]};
            ck_filt <= ck_vote;
            fall    <= ck_filt & ~ck_vote;
            dt_meta <= dt;
            dt_sync <= dt_meta;
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter. Drives the shared clock and
// data lines open-drain (Oe=1 pulls low) through the request-to-send sequence.
// Optional device watchdog: compile with PS2_TX_WATCHDOG_EN defined.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] di,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2Ck,
    input  logic       ps2Dt,
    output logic       ps2CkOe,
    output logic       ps2DtOe
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

    if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ps2_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    ps2_tx_state_t          state;
    ps2_tx_state_t          state_next;
    logic [INH_W-1:0]       inh_cnt;
    logic [INH_W-1:0]       inh_cnt_next;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt_next;
    tx_frame_t              frame;
    tx_frame_t              frame_next;

    logic                   busy_next;
    logic                   done_next;
    logic                   error_next;
    logic                   ck_oe_next;
    logic                   dt_oe_next;

    logic                   ck_filt;
    logic                   dt_sync;
    logic                   fall;
    logic                   accept;
    logic                   ack_fall;
    logic                   line_idle;
    logic                   wd_timeout;

    ps2_line_sync u_line_sync (
        .clock   (clock),
        .reset   (reset),
        .ck      (ps2Ck),
        .dt      (ps2Dt),
        .ck_filt (ck_filt),
        .dt_sync (dt_sync),
        .fall    (fall)
    );

    // A start is taken only from a fully idle block (busy also covers the done/error cycle)
    assign accept    = (state == IDLE) && start && !busy;
    assign ack_fall  = (state == ACK) && fall && (bit_cnt == BIT_CNT_W'(ACK_FALL - 1));
    assign line_idle = ck_filt && dt_sync;

`ifdef PS2_TX_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_active;

    assign wd_active  = (state == REQ) || (state == DATA) || (state == ACK) || (state == WAITIDLE);
    assign wd_timeout = wd_active && !fall && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Device watchdog: restarts on every device clock and on entry to REQ
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (fall || !wd_active) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    assign wd_timeout = 1'b0;
`endif

    // State, datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            inh_cnt <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            ps2CkOe <= 1'b0;
            ps2DtOe <= 1'b0;
        end else begin
            state   <= state_next;
            inh_cnt <= inh_cnt_next;
            bit_cnt <= bit_cnt_next;
            frame   <= frame_next;
            busy    <= busy_next;
            done    <= done_next;
            error   <= error_next;
            ps2CkOe <= ck_oe_next;
            ps2DtOe <= dt_oe_next;
        end
    end

    // Next state plus inhibit timer, falling-edge counter and byte latch
    always_comb begin
        state_next   = state;
        inh_cnt_next = inh_cnt;
        bit_cnt_next = bit_cnt;
        frame_next   = frame;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = INHIBIT;
                    inh_cnt_next = INH_W'(INHIBIT_CYCLES - 1);
                    bit_cnt_next = '0;
                    frame_next   = tx_frame_t'{parity: odd_parity(di), data: di};
                end
            end
            INHIBIT: begin
                if (inh_cnt == '0) begin
                    state_next = REQ;
                end else begin
                    inh_cnt_next = inh_cnt - INH_W'(1);
                end
            end
            REQ: begin
                if (fall) begin
                    state_next   = DATA;
                    bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                end
            end
            DATA: begin
                if (fall) begin
                    bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(STOP_FALL - 1)) begin
                        state_next = ACK;
                    end
                end
            end
            ACK: begin
                if (ack_fall) begin
                    bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                    state_next   = dt_sync ? IDLE : WAITIDLE;
                end
            end
            WAITIDLE: begin
                if (line_idle) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (wd_timeout) begin
            state_next = IDLE;
        end

        if (state_next == IDLE) begin
            bit_cnt_next = '0;
        end
    end

    // Next values of the registered outputs
    always_comb begin
        ck_oe_next = (state_next == INHIBIT);
        dt_oe_next = ps2DtOe;
        done_next  = 1'b0;
        error_next = 1'b0;
        busy_next  = (state != IDLE) || (state_next != IDLE);

        // Present the next frame bit while the device holds the clock low
        if ((state == REQ || state == DATA) && fall) begin
            if (bit_cnt < BIT_CNT_W'(LAST_DATA_FALL - 1)) begin
                dt_oe_next = ~frame.data[bit_cnt[2:0]];
            end else if (bit_cnt == BIT_CNT_W'(LAST_DATA_FALL - 1)) begin
                dt_oe_next = ~frame.parity;
            end else begin
                dt_oe_next = 1'b0;
            end
        end

        if (ack_fall && dt_sync) begin
            error_next = 1'b1;
        end

        if (state == WAITIDLE && line_idle) begin
            done_next = 1'b1;
        end

        if (wd_timeout && !done_next) begin
            error_next = 1'b1;
        end

        // Start bit goes low in the last inhibit cycle
        if (state_next == INHIBIT && inh_cnt_next == '0) begin
            dt_oe_next = 1'b1;
        end

        if (state_next == IDLE) begin
            dt_oe_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: randomized bench for ps2_tx with a PS/2 device model on the
// open-drain lines and a response scoreboard (done/error + captured frame).
module tb_ps2_tx;

    localparam int unsigned INH  = 16;
    localparam int unsigned TMO  = 2000;
    localparam int          HALF = 140;   // 20 us half period at 7 MHz

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] di    = 8'h00;
    logic       busy;
    logic       done;
    logic       error;
    logic       ps2CkOe;
    logic       ps2DtOe;

    logic       dev_ck_low = 1'b0;
    logic       dev_dt_low = 1'b0;
    logic       line_ck;
    logic       line_dt;

    assign line_ck = ~(ps2CkOe | dev_ck_low);
    assign line_dt = ~(ps2DtOe | dev_dt_low);

    ps2_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .di      (di),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .ps2Ck   (line_ck),
        .ps2Dt   (line_dt),
        .ps2CkOe (ps2CkOe),
        .ps2DtOe (ps2DtOe)
    );

    initial forever #5 clock = ~clock;

    int checks   = 0;
    int fails    = 0;
    int issued   = 0;
    int resp_cnt = 0;

    typedef struct {
        bit         is_done;
        bit         check_frame;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [9:0] cap = '0;
    bit         after_resp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bits as the device reads them: 8 data LSB first, odd parity, stop
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int   ones;
        logic par;
        ones = $countones(d);
        par  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    // Scoreboard monitor: pops one expectation per done/error pulse
    always @(negedge clock) begin
        if (after_resp) begin
            chk("busy_fall_after_resp", 32'(busy), 32'd0);
            after_resp = 1'b0;
        end
        if (reset && (done || error)) begin
            resp_cnt++;
            chk("done_error_exclusive", 32'(done & error), 32'd0);
            chk("busy_in_resp_cycle", 32'(busy), 32'd1);
            chk("lines_released", 32'({ps2CkOe, ps2DtOe}), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'({done, error}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_done", 32'(done), 32'(mon_e.is_done));
                chk("resp_error", 32'(error), 32'(!mon_e.is_done));
                if (mon_e.check_frame) begin
                    chk("frame_bits", 32'(cap), 32'(model_frame(mon_e.data)));
                end
            end
            after_resp = 1'b1;
        end
    end

    // Device: waits for request-to-send, then clocks nclk bits
    task automatic dev_frame(input bit ack, input int nclk);
        int         n;
        int         hi;
        logic [3:0] idx;
        n  = 0;
        hi = 0;
        while (!ps2CkOe && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("inhibit_seen", 32'(ps2CkOe), 32'd1);
        if (!ps2CkOe) return;
        chk("busy_with_ckoe", 32'(busy), 32'd1);
        while (ps2CkOe && hi < 5000) begin
            @(negedge clock);
            hi++;
        end
        chk("inhibit_len", 32'(hi), 32'(INH));
        chk("start_bit_low", 32'(ps2DtOe), 32'd1);
        repeat (50) @(negedge clock);
        for (int i = 1; i <= nclk; i++) begin
            dev_ck_low = 1'b1;
            repeat (HALF) @(negedge clock);
            dev_ck_low = 1'b0;
            if (i <= 10) begin
                idx      = 4'(i - 1);
                cap[idx] = line_dt;
            end
            repeat (20) @(negedge clock);
            if (i == 10 && ack) dev_dt_low = 1'b1;
            if (i == 11) dev_dt_low = 1'b0;
            repeat (HALF - 20) @(negedge clock);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("busy_return_idle", 32'(busy), 32'd0);
    endtask

    // One complete command; poke adds starts mid-frame and in the done cycle
    task automatic run_frame(input logic [7:0] d, input bit ack, input bit poke);
        @(negedge clock);
        chk("idle_before_start", 32'(busy), 32'd0);
        di    = d;
        start = 1'b1;
        exp_q.push_back(exp_t'{is_done: ack, check_frame: 1'b1, data: d});
        issued++;
        @(negedge clock);
        start = 1'b0;
        di    = 8'($urandom);
        chk("busy_rise", 32'(busy), 32'd1);
        fork
            dev_frame(ack, 11);
            begin
                if (poke) begin
                    repeat (600) @(negedge clock);
                    di    = 8'h55;
                    start = 1'b1;
                    @(negedge clock);
                    start = 1'b0;
                end
            end
            begin
                int   n;
                logic bad;
                n   = 0;
                bad = 1'b0;
                if (poke) begin
                    while (!(done || error) && n < 20000) begin
                        @(negedge clock);
                        n++;
                    end
                    chk("resp_before_limit", 32'(done | error), 32'd1);
                    di    = 8'hA5;
                    start = 1'b1;
                    @(negedge clock);
                    start = 1'b0;
                    repeat (4) begin
                        @(negedge clock);
                        bad = bad | busy | ps2CkOe;
                    end
                    chk("start_in_done_ignored", 32'(bad), 32'd0);
                end
            end
        join
        wait_idle();
        repeat (10) @(negedge clock);
    endtask

    task automatic reset_test();
        @(negedge clock);
        di    = 8'hED;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        dev_frame(1'b0, 4);
        dev_ck_low = 1'b1;
        repeat (20) @(negedge clock);
        chk("dt_driven_before_reset", 32'(ps2DtOe), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("reset_releases_lines", 32'({ps2CkOe, ps2DtOe, busy, done, error}), 32'd0);
        @(negedge clock);
        dev_ck_low = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        chk("idle_after_reset", 32'({busy, ps2CkOe, ps2DtOe}), 32'd0);
    endtask

`ifdef PS2_TX_WATCHDOG_EN
    task automatic watchdog_test();
        int n;
        @(negedge clock);
        di    = 8'h3C;
        start = 1'b1;
        exp_q.push_back(exp_t'{is_done: 1'b0, check_frame: 1'b0, data: 8'h3C});
        issued++;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!ps2CkOe && n < 200) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (ps2CkOe && n < 5000) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (!error && n < 5000) begin
            @(negedge clock);
            n++;
        end
        chk("watchdog_latency", 32'(n), 32'(TMO));
        wait_idle();
        repeat (10) @(negedge clock);
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete at %0t", $time);
        $fatal(1, "global time limit exceeded");
    end

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", 32'({busy, done, error, ps2CkOe, ps2DtOe}), 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        chk("post_reset_outputs", 32'({busy, done, error, ps2CkOe, ps2DtOe}), 32'd0);

        run_frame(8'hED, 1'b1, 1'b0);
        run_frame(8'hFF, 1'b1, 1'b0);
        run_frame(8'h00, 1'b1, 1'b0);
        run_frame(8'h01, 1'b1, 1'b0);
        run_frame(8'hED, 1'b1, 1'b1);
        run_frame(8'($urandom), 1'b0, 1'b0);
        reset_test();
        run_frame(8'hED, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            run_frame(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
        end
`ifdef PS2_TX_WATCHDOG_EN
        watchdog_test();
`endif
        repeat (20) @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("responses_seen", 32'(resp_cnt), 32'(issued));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
